// File: rtl/fmdll_lock_ctrl_if.sv
// Control/status bundle between the FMDLL lock controller and its environment
// (M/N divider counters on the input side, delay line on the output side).
interface fmdll_lock_ctrl_if #(
  parameter int CODE_W = 6
);
  // No valid/ready pairs here: start and m_wrap are one-cycle strobes sampled on
  // clk_ext, en is a level, n_wrap_tgl is a free-running toggle from another clock
  // domain; the controller never applies backpressure and consumes every strobe.
  logic              en;
  logic              start;
  logic              m_wrap;
  logic              n_wrap_tgl;
  logic [CODE_W-1:0] dcode;
  logic              locked;
  logic              busy;
  logic              err;
  logic [2:0]        state_dbg;

  modport master (
    output en, start, m_wrap, n_wrap_tgl,
    input  dcode, locked, busy, err, state_dbg
  );

  modport slave (
    input  en, start, m_wrap, n_wrap_tgl,
    output dcode, locked, busy, err, state_dbg
  );
endinterface

// File: rtl/fmdll_lock_ctrl.sv
// FMDLL lock controller: SAR acquisition of the delay code, then +/-1 tracking.
// Optional watchdog enabled by defining FMDLL_LOCK_TIMEOUT_EN.
module fmdll_lock_ctrl #(
  parameter int CODE_W   = 6,
  parameter int WIN      = 4,
  parameter int CNT_W    = 8,
  parameter int TOL      = 0,
  parameter int SETTLE   = 1,
  parameter int LOCK_CNT = 3
`ifdef FMDLL_LOCK_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic             clk_ext,
  input  logic             rst_n,
  fmdll_lock_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SAR_SETTLE = 3'd1,
    S_SAR_MEAS   = 3'd2,
    S_SAR_EVAL   = 3'd3,
    S_TRK_SETTLE = 3'd4,
    S_TRK_MEAS   = 3'd5,
    S_TRK_EVAL   = 3'd6
  } state_e;

  localparam int MC_MAX = (SETTLE > WIN) ? SETTLE : WIN;
  localparam int MC_W   = $clog2(MC_MAX + 1);
  localparam int BIT_W  = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int IR_W   = $clog2(LOCK_CNT + 1);
  localparam int WIN_LO = WIN - TOL;
  localparam int WIN_HI = WIN + TOL;

  localparam logic [CODE_W-1:0] CODE_MID    = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [CODE_W-1:0] CODE_MAX    = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [MC_W-1:0]   SETTLE_LAST = MC_W'(SETTLE - 1);
  localparam logic [MC_W-1:0]   WIN_LAST    = MC_W'(WIN - 1);
  localparam logic [BIT_W-1:0]  BIT_TOP     = BIT_W'(CODE_W - 1);
  localparam logic [IR_W-1:0]   LOCK_C      = IR_W'(LOCK_CNT);

  state_e             state_q, state_d;
  logic [CODE_W-1:0]  dcode_q, dcode_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [MC_W-1:0]    mcnt_q, mcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               open_q, open_d;
  logic [IR_W-1:0]    inrange_q, inrange_d;
  logic               locked_q, locked_d;
  logic               tgl_s1_q, tgl_s1_d;
  logic               tgl_s2_q, tgl_s2_d;
  logic               tgl_s3_q, tgl_s3_d;
  logic               n_evt;
  logic               abort;
  int                 cnt_i;

`ifdef FMDLL_LOCK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            wd_hit;
`endif

  // Two synchroniser stages plus an edge register; each toggle becomes one n_evt.
  assign n_evt = tgl_s2_q ^ tgl_s3_q;

  always_comb begin
    state_d   = state_q;
    dcode_d   = dcode_q;
    bit_d     = bit_q;
    mcnt_d    = mcnt_q;
    cnt_d     = cnt_q;
    open_d    = open_q;
    inrange_d = inrange_q;
    locked_d  = locked_q;
    tgl_s1_d  = bus.n_wrap_tgl;
    tgl_s2_d  = tgl_s1_q;
    tgl_s3_d  = tgl_s2_q;
    cnt_i     = int'(cnt_q);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          bit_d    = BIT_TOP;
          dcode_d  = CODE_MID;
          locked_d = 1'b0;
          mcnt_d   = '0;
          state_d  = S_SAR_SETTLE;
        end
      end
      S_SAR_SETTLE, S_TRK_SETTLE: begin
        if (SETTLE == 0 || (bus.m_wrap && mcnt_q == SETTLE_LAST)) begin
          mcnt_d  = '0;
          cnt_d   = '0;
          open_d  = 1'b0;
          state_d = (state_q == S_SAR_SETTLE) ? S_SAR_MEAS : S_TRK_MEAS;
        end else if (bus.m_wrap) begin
          mcnt_d = mcnt_q + 1'b1;
        end
      end
      S_SAR_MEAS, S_TRK_MEAS: begin
        if (!open_q) begin
          // The opening m_wrap only arms the window; a coincident n_evt is dropped.
          if (bus.m_wrap) begin
            open_d = 1'b1;
            mcnt_d = '0;
          end
        end else begin
          if (n_evt && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (bus.m_wrap) begin
            if (mcnt_q == WIN_LAST) begin
              state_d = (state_q == S_SAR_MEAS) ? S_SAR_EVAL : S_TRK_EVAL;
            end else begin
              mcnt_d = mcnt_q + 1'b1;
            end
          end
        end
      end
      S_SAR_EVAL: begin
        mcnt_d = '0;
        if (cnt_i < WIN) dcode_d[bit_q] = 1'b0;
        if (bit_q != '0) begin
          bit_d          = bit_q - 1'b1;
          dcode_d[bit_d] = 1'b1;
          state_d        = S_SAR_SETTLE;
        end else begin
          state_d = S_TRK_SETTLE;
        end
      end
      S_TRK_EVAL: begin
        mcnt_d  = '0;
        state_d = S_TRK_SETTLE;
        if (cnt_i > WIN_HI) begin
          if (dcode_q != CODE_MAX) dcode_d = dcode_q + 1'b1;
          inrange_d = '0;
          locked_d  = 1'b0;
        end else if (cnt_i < WIN_LO) begin
          if (dcode_q != '0) dcode_d = dcode_q - 1'b1;
          inrange_d = '0;
          locked_d  = 1'b0;
        end else begin
          if (inrange_q != LOCK_C) inrange_d = inrange_q + 1'b1;
          if (inrange_d == LOCK_C) locked_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef FMDLL_LOCK_TIMEOUT_EN
    err_d  = err_q;
    wd_d   = '0;
    wd_hit = 1'b0;
    if (state_q != S_IDLE && !bus.m_wrap) begin
      if (wd_q == WD_LAST) begin
        wd_hit = 1'b1;
        err_d  = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
    abort = !bus.en || wd_hit;
`else
    abort = !bus.en;
`endif

    // Leaving to IDLE keeps the delay code so the line does not jump on disable.
    if (abort) begin
      state_d   = S_IDLE;
      locked_d  = 1'b0;
      bit_d     = '0;
      mcnt_d    = '0;
      cnt_d     = '0;
      open_d    = 1'b0;
      inrange_d = '0;
      dcode_d   = dcode_q;
    end
  end

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dcode_q   <= CODE_MID;
      bit_q     <= '0;
      mcnt_q    <= '0;
      cnt_q     <= '0;
      open_q    <= 1'b0;
      inrange_q <= '0;
      locked_q  <= 1'b0;
      tgl_s1_q  <= 1'b0;
      tgl_s2_q  <= 1'b0;
      tgl_s3_q  <= 1'b0;
`ifdef FMDLL_LOCK_TIMEOUT_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dcode_q   <= dcode_d;
      bit_q     <= bit_d;
      mcnt_q    <= mcnt_d;
      cnt_q     <= cnt_d;
      open_q    <= open_d;
      inrange_q <= inrange_d;
      locked_q  <= locked_d;
      tgl_s1_q  <= tgl_s1_d;
      tgl_s2_q  <= tgl_s2_d;
      tgl_s3_q  <= tgl_s3_d;
`ifdef FMDLL_LOCK_TIMEOUT_EN
      wd_q      <= wd_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus.dcode     = dcode_q;
  assign bus.locked    = locked_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.state_dbg = state_q;
`ifdef FMDLL_LOCK_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: doc/fmdll_lock_ctrl.md
Name: fmdll_lock_ctrl

Overview:
- Lock controller for the FMDLL M/N divider pair, running in the clk_ext domain.
- Measures how many N-divider wraps (clk_out domain) fall inside a window of WIN M-divider wraps (clk_ext domain).
- Drives the delay-line code by binary search (SAR), then tracks in ±1 steps, and reports lock.
- Sits between the M/N clock counters and the delay line.

Parameters:
- CODE_W, 6: delay-code width; larger code gives longer delay and lower clk_out frequency.
- WIN, 4: number of M wraps per measurement window; this is also the expected N-wrap count.
- CNT_W, 8: width of the measurement counter; the counter saturates at 2^CNT_W-1.
- TOL, 0: allowed deviation of the count from WIN that is still in range.
- SETTLE, 1: number of m_wrap pulses discarded after every code change.
- LOCK_CNT, 3: number of consecutive in-range measurements required to assert locked.
- TIMEOUT_CYC, 1024: watchdog limit in clk_ext cycles (optional feature only).

Ports:
- clk_ext  in  1  reference clock; the only clock of this block.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  level enable; deasserting it returns the block to IDLE.
- start  in  1  one-cycle pulse; begins acquisition from IDLE.
- m_wrap  in  1  one-cycle pulse in the clk_ext domain on every M_counter wrap.
- n_wrap_tgl  in  1  toggles in the clk_out domain on every N_counter wrap; asynchronous to clk_ext.
- dcode  out  CODE_W  delay-line control code.
- locked  out  1  lock indicator.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky watchdog error.

Behaviour:
- Reset (async, rst_n=0): dcode=2^(CODE_W-1); locked=0; busy=0; err=0; state=IDLE; all counters=0; synchroniser flops=0.
- Reset mid-operation returns to these values immediately.
- n_wrap_tgl passes through a 2-FF synchroniser plus one edge register. Each synchronised toggle edge is one n_evt; latency is 3 clk_ext cycles.
- States: IDLE, SAR_SETTLE, SAR_MEAS, SAR_EVAL, TRK_SETTLE, TRK_MEAS, TRK_EVAL.
- IDLE:
  - start&en: set bit=CODE_W-1, dcode=2^(CODE_W-1), locked=0, go to SAR_SETTLE.
  - start while not IDLE is ignored.
- *_SETTLE: count SETTLE m_wrap pulses, then go to *_MEAS.
- *_MEAS:
  - The window opens on the first m_wrap and closes on the WIN-th m_wrap after that.
  - An n_evt in the same cycle as the opening m_wrap is not counted.
  - An n_evt in the same cycle as the closing m_wrap is counted.
  - cnt saturates at its maximum.
  - On close, go to *_EVAL.
- SAR_EVAL (1 cycle):
  - If cnt<WIN, clear dcode[bit]; otherwise keep it.
  - If bit>0: bit-1, set dcode[bit-1], go to SAR_SETTLE.
  - Else go to TRK_SETTLE.
  - The final SAR result is therefore in dcode after bit 0 is evaluated.
- TRK_EVAL (1 cycle):
  - cnt>WIN+TOL: dcode+1, saturating at 2^CODE_W-1.
  - cnt<WIN-TOL: dcode-1, saturating at 0. WIN-TOL is computed signed; it never underflows.
  - In range: inrange_cnt+1, saturating. Set locked=1 when inrange_cnt reaches LOCK_CNT.
  - Out of range: inrange_cnt=0 and locked=0 in the same cycle.
  - Then go to TRK_SETTLE. SETTLE also applies when dcode did not change.
- en=0 in any state: go to IDLE on the next edge; locked=0; dcode holds its value; counters clear.
- en=0 together with start: stay in IDLE.
- cnt clears on entry to every *_MEAS.

Optional Feature:
- Macro: FMDLL_LOCK_TIMEOUT_EN.
- Defined:
  - A watchdog counts clk_ext cycles since the last m_wrap while busy=1.
  - When the count reaches TIMEOUT_CYC: err=1 (sticky until rst_n), state=IDLE, locked=0, dcode holds.
  - start is still accepted after a timeout; err stays high.
- Not defined: err is tied to 0 and no watchdog logic is present.

Test Plan:
- SAR convergence: rst_n low then high, en=1, start pulse. Clock model gives N-wraps per window >4 for dcode<20, =4 for dcode 20..22, <4 for dcode>22.
  -> SAR sequence 32, 16, 24, 20, 22, 23; final dcode=22; locked=1 after 3 TRK windows; busy=1 throughout.
- Tracking: after lock, shift the in-range band to 24..26.
  -> locked drops on the first TRK_EVAL; dcode steps 23 then 24; locked reasserts after 3 in-range windows.
- Saturation: model always too fast.
  -> SAR ends at dcode=63; every TRK window leaves dcode at 63; locked stays 0.
- Synchroniser boundary: inject n_wrap_tgl edges aligned with the opening and closing m_wrap (after the 3-cycle latency).
  -> the opening-aligned edge is excluded and the closing-aligned edge is included; cnt=4 for 4 evenly spaced edges plus the boundary edges as specified.
- Abort: deassert en during SAR_MEAS, or pulse rst_n low during TRK.
  -> en case: IDLE next cycle, busy=0, dcode holds. Reset case: dcode=32, locked=0, busy=0 asynchronously.
- FMDLL_LOCK_TIMEOUT_EN defined: stop m_wrap during SAR_SETTLE.
  -> err=1 and busy=0 exactly 1024 cycles after the last m_wrap; a new start restarts SAR with err still 1.
